alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle control unit that issues operations to the 8-bit ALU.
- Accepts one instruction per valid/ready handshake and decodes it into ALU opcode and operands.
- Reads operands from an internal register file, captures the ALU result, and writes it back along with a registered Zero flag.
- Sits between instruction fetch and the ALU as the initiator side of the ALU operation interface.

Parameters:
AW, 2, register address width; register file holds 2**AW entries; legal range 1..4
DW, 8, datapath width; matches ALU DW

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
instr  in  9  instruction word: [8:6] op, [5:4] rd, [3:2] rs, [3:0] imm4 (LDI only); with generic AW: rd=[5 -: AW], rs=[3 -: AW]
instr_valid  in  1  instruction offered
instr_ready  out  1  sequencer can accept (high only in IDLE)
alu_op  out  3  ALU operation code
alu_in1  out  DW  ALU operand 1
alu_in2  out  DW  ALU operand 2
alu_out  in  DW  ALU result
alu_zero  in  1  ALU zero indication
done  out  1  one-cycle pulse: instruction retired (WB cycle)
zero_flag  out  1  registered Zero of last retired instruction
dbg_addr  in  AW  register-file observation address
dbg_data  out  DW  combinational rf[dbg_addr]

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all rf entries=0; zero_flag=0; done=0; latched instr=0. Reset wins over every other event, including mid-instruction. An instruction in flight is discarded with no write and no done.
- FSM states and transitions:
  - IDLE: instr_ready=1; alu_op/in1/in2 driven to 0. On instr_valid=1 at a rising edge, latch instr and go to EXEC.
  - EXEC: instr_ready=0; drive the ALU combinationally from the latched instr and current rf; capture alu_out and alu_zero into result regs at the edge; go to WB.
  - WB: instr_ready=0; done=1; rf[rd] <= result; zero_flag <= result_zero; go to IDLE.
- Timing:
  - Handshake edge T; EXEC is cycle T+1; WB/done is cycle T+2.
  - The new rf value and zero_flag are visible from T+3.
  - Throughput is 1 instruction per 3 cycles. instr_valid held high is not consumed again until IDLE.
- Decode (op = instr[8:6]):
  - 000 INC: in1=rf[rd], in2=0.
  - 001 DEC: in1=rf[rd], in2=0.
  - 010 XOR, 100 SHL, 101 SHR, 110 AND: in1=rf[rd], in2=rf[rs].
  - 011 RXOR: in1=rf[rd], in2=0; result is 0 or 1.
  - 111 LDI: in1=zero-extended imm4, in2=0; the ALU passes input1.
  - In every case alu_op = op. Result always writes rd.
- Arithmetic: all DW-bit modulo; INC of all-ones gives 0, DEC of 0 gives all-ones. Shift amount is the full rf[rs] value; shifts of DW or more yield 0.
- rd==rs is legal; the operand is read in EXEC, before the write.
- Zero flag is taken from alu_zero, not recomputed.
- dbg_data is purely combinational and has no side effects.

Decomposition:
- Package alu_pkg: enum alu_op_t {OP_INC=3'b000, OP_DEC, OP_XOR, OP_RXOR, OP_SHL, OP_SHR, OP_AND, OP_LDI=3'b111}; state enum seq_state_t {IDLE, EXEC, WB}; instruction field position localparams.
- Sub-module reg_file (2**AW x DW): one synchronous write port, two combinational read ports (operand, debug), synchronous reset clears all entries.

Test Plan:
- Reset: hold reset 2 cycles -> instr_ready=1, done=0, zero_flag=0, dbg_data=0 for all 4 addresses, alu_op=0.
- LDI r1,5 (9'b111_01_0101) at edge T -> at T+1 alu_op=111 and alu_in1=0x05; done=1 only at T+2; rf[1]=0x05 and zero_flag=0 from T+3; instr_ready low at T+1 and T+2.
- LDI r2,3 then SHL r1,r2 with r1=5 -> rf[1]=0x28, zero_flag=0. Then SHR r1,r2 -> 0x05. Then AND r1,r2 -> 0x01.
- XOR r1,r1 with r1=0x05 -> rf[1]=0x00, zero_flag=1. Then RXOR r2 with r2=0x07 -> rf[2]=0x01, zero_flag=0.
- Wrap: DEC r0 from 0 -> 0xFF, zero_flag=0. Then INC r0 -> 0x00, zero_flag=1.
- Back-to-back and reset: instr_valid held high with 3 instructions -> each accepted exactly 3 cycles apart with 3 done pulses. Separately, assert reset during EXEC of LDI r3,9 -> next cycle IDLE, no done, rf[3]=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and instruction field positions for the ALU sequencer.
// Opcode values match the 8-bit ALU encoding.
package alu_pkg;

    localparam int INSTR_W = 9;
    localparam int OP_MSB  = 8;
    localparam int OP_W    = 3;
    localparam int RD_MSB  = 5;
    localparam int RS_MSB  = 3;
    localparam int IMM_MSB = 3;
    localparam int IMM_W   = 4;

    typedef enum logic [OP_W-1:0] {
        OP_INC  = 3'b000,
        OP_DEC,
        OP_XOR,
        OP_RXOR,
        OP_SHL,
        OP_SHR,
        OP_AND,
        OP_LDI  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } seq_state_t;

    // Two-register ops take rf[rs] as the second operand.
    function automatic logic uses_rs(alu_op_t op);
        return op inside {OP_XOR, OP_SHL, OP_SHR, OP_AND};
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// ALU operation bus: the sequencer is master, the ALU is slave.
// Operands and opcode flow out, result and zero flow back.
interface alu_sequencer_if
    import alu_pkg::*;
#(
    parameter int DW = 8
);

    logic [OP_W-1:0] alu_op;
    logic [DW-1:0]   alu_in1;
    logic [DW-1:0]   alu_in2;
    logic [DW-1:0]   alu_out;
    logic            alu_zero;

    modport master (
        output alu_op,
        output alu_in1,
        output alu_in2,
        input  alu_out,
        input  alu_zero
    );

    modport slave (
        input  alu_op,
        input  alu_in1,
        input  alu_in2,
        output alu_out,
        output alu_zero
    );

endinterface

// File: rtl/reg_file.sv
// 2**AW x DW register file: one sync write port, two operand reads
// and one debug read, all combinational; sync reset clears every entry.
module reg_file #(
    parameter int AW = 2,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a  = mem[raddr_a];
    assign rdata_b  = mem[raddr_b];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Three-cycle IDLE/EXEC/WB sequencer driving the 8-bit ALU from an
// internal register file and writing the result back with a Zero flag.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int AW = 2,
    parameter int DW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    alu_sequencer_if.master    alu,
    output logic               done,
    output logic               zero_flag,
    input  logic [AW-1:0]      dbg_addr,
    output logic [DW-1:0]      dbg_data
);

    seq_state_t         state;
    logic [INSTR_W-1:0] ir;
    logic [DW-1:0]      res;
    logic               res_zero;

    alu_op_t       op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs;
    logic [DW-1:0] rf_rd;
    logic [DW-1:0] rf_rs;

    assign op = alu_op_t'(ir[OP_MSB -: OP_W]);
    assign rd = ir[RD_MSB -: AW];
    assign rs = ir[RS_MSB -: AW];

    reg_file #(
        .AW(AW),
        .DW(DW)
    ) u_rf (
        .clk      (clk),
        .reset    (reset),
        .we       (state == WB),
        .waddr    (rd),
        .wdata    (res),
        .raddr_a  (rd),
        .rdata_a  (rf_rd),
        .raddr_b  (rs),
        .rdata_b  (rf_rs),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Operands are only presented in EXEC; rd==rs reads the pre-write value.
    always_comb begin
        alu.alu_op  = '0;
        alu.alu_in1 = '0;
        alu.alu_in2 = '0;
        if (state == EXEC) begin
            alu.alu_op = op;
            unique case (1'b1)
                op == OP_LDI: begin
                    alu.alu_in1 = DW'(ir[IMM_MSB -: IMM_W]);
                end
                uses_rs(op): begin
                    alu.alu_in1 = rf_rd;
                    alu.alu_in2 = rf_rs;
                end
                default: begin
                    alu.alu_in1 = rf_rd;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ir          <= '0;
            res         <= '0;
            res_zero    <= 1'b0;
            zero_flag   <= 1'b0;
            done        <= 1'b0;
            instr_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir          <= instr;
                        state       <= EXEC;
                        instr_ready <= 1'b0;
                    end
                end
                EXEC: begin
                    res      <= alu.alu_out;
                    res_zero <= alu.alu_zero;
                    state    <= WB;
                    done     <= 1'b1;
                end
                WB: begin
                    zero_flag   <= res_zero;
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 8-bit ALU model.
`timescale 1ns/1ps
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic       done;
    logic       zero_flag;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int n_chk  = 0;
    int n_fail = 0;

    alu_sequencer_if #(.DW(8)) alu_bus ();

    alu_sequencer #(
        .AW(2),
        .DW(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu         (alu_bus.master),
        .done        (done),
        .zero_flag   (zero_flag),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #10 clk = ~clk;

    // Reference ALU
    always_comb begin
        logic [7:0] r;
        r = 8'h00;
        case (alu_bus.alu_op)
            3'b000: r = alu_bus.alu_in1 + 8'd1;
            3'b001: r = alu_bus.alu_in1 - 8'd1;
            3'b010: r = alu_bus.alu_in1 ^ alu_bus.alu_in2;
            3'b011: r = {7'b0, ^alu_bus.alu_in1};
            3'b100: r = (alu_bus.alu_in2 >= 8) ? 8'h00 : alu_bus.alu_in1 << alu_bus.alu_in2;
            3'b101: r = (alu_bus.alu_in2 >= 8) ? 8'h00 : alu_bus.alu_in1 >> alu_bus.alu_in2;
            3'b110: r = alu_bus.alu_in1 & alu_bus.alu_in2;
            default: r = alu_bus.alu_in1;
        endcase
        alu_bus.alu_out  = r;
        alu_bus.alu_zero = (r == 8'h00);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rf(input string name, input logic [1:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        chk(name, {24'b0, dbg_data}, {24'b0, exp});
    endtask

    typedef struct {
        string      name;
        logic [8:0] instr;
        logic [1:0] rd;
        logic [2:0] op;
        logic [7:0] in1;
        logic [7:0] in2;
        logic [7:0] res;
        logic       z;
    } vec_t;

    vec_t tv[14];

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        instr       = v.instr;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        chk({v.name, " op"},    {29'b0, alu_bus.alu_op}, {29'b0, v.op});
        chk({v.name, " in1"},   {24'b0, alu_bus.alu_in1}, {24'b0, v.in1});
        chk({v.name, " in2"},   {24'b0, alu_bus.alu_in2}, {24'b0, v.in2});
        chk({v.name, " rdy_ex"}, {31'b0, instr_ready}, 32'd0);
        chk({v.name, " done_ex"}, {31'b0, done}, 32'd0);
        @(posedge clk);
        #1;
        chk({v.name, " done_wb"}, {31'b0, done}, 32'd1);
        @(posedge clk);
        #1;
        chk({v.name, " done_idle"}, {31'b0, done}, 32'd0);
        chk({v.name, " rdy_idle"}, {31'b0, instr_ready}, 32'd1);
        chk({v.name, " zero"}, {31'b0, zero_flag}, {31'b0, v.z});
        chk_rf({v.name, " rf"}, v.rd, v.res);
    endtask

    initial begin
        int acc_c[3];
        int nacc;
        int ndone;

        tv[0]  = '{"LDI r2,3",  9'b111_10_0011, 2'd2, 3'd7, 8'h03, 8'h00, 8'h03, 1'b0};
        tv[1]  = '{"SHL r1,r2", 9'b100_01_10_00, 2'd1, 3'd4, 8'h05, 8'h03, 8'h28, 1'b0};
        tv[2]  = '{"SHR r1,r2", 9'b101_01_10_00, 2'd1, 3'd5, 8'h28, 8'h03, 8'h05, 1'b0};
        tv[3]  = '{"AND r1,r2", 9'b110_01_10_00, 2'd1, 3'd6, 8'h05, 8'h03, 8'h01, 1'b0};
        tv[4]  = '{"LDI r1,5",  9'b111_01_0101, 2'd1, 3'd7, 8'h05, 8'h00, 8'h05, 1'b0};
        tv[5]  = '{"XOR r1,r1", 9'b010_01_01_00, 2'd1, 3'd2, 8'h05, 8'h05, 8'h00, 1'b1};
        tv[6]  = '{"LDI r2,7",  9'b111_10_0111, 2'd2, 3'd7, 8'h07, 8'h00, 8'h07, 1'b0};
        tv[7]  = '{"RXOR r2",   9'b011_10_00_00, 2'd2, 3'd3, 8'h07, 8'h00, 8'h01, 1'b0};
        tv[8]  = '{"DEC r0",    9'b001_00_00_00, 2'd0, 3'd1, 8'h00, 8'h00, 8'hFF, 1'b0};
        tv[9]  = '{"INC r0",    9'b000_00_00_00, 2'd0, 3'd0, 8'hFF, 8'h00, 8'h00, 1'b1};
        tv[10] = '{"LDI r3,9",  9'b111_11_1001, 2'd3, 3'd7, 8'h09, 8'h00, 8'h09, 1'b0};
        tv[11] = '{"LDI r1,15", 9'b111_01_1111, 2'd1, 3'd7, 8'h0F, 8'h00, 8'h0F, 1'b0};
        tv[12] = '{"SHL r1,r3", 9'b100_01_11_00, 2'd1, 3'd4, 8'h0F, 8'h09, 8'h00, 1'b1};
        tv[13] = '{"SHR r3,r3", 9'b101_11_11_00, 2'd3, 3'd5, 8'h09, 8'h09, 8'h00, 1'b1};

        reset       = 1'b1;
        instr       = 9'h000;
        instr_valid = 1'b0;
        dbg_addr    = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst ready", {31'b0, instr_ready}, 32'd1);
        chk("rst done",  {31'b0, done}, 32'd0);
        chk("rst zero",  {31'b0, zero_flag}, 32'd0);
        chk("rst aluop", {29'b0, alu_bus.alu_op}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            chk_rf($sformatf("rst rf%0d", a), 2'(a), 8'h00);
        end

        // LDI r1,5 with cycle-by-cycle timing
        @(negedge clk);
        instr       = 9'b111_01_0101;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        chk("ldi T+1 op",    {29'b0, alu_bus.alu_op}, 32'd7);
        chk("ldi T+1 in1",   {24'b0, alu_bus.alu_in1}, 32'h05);
        chk("ldi T+1 ready", {31'b0, instr_ready}, 32'd0);
        chk("ldi T+1 done",  {31'b0, done}, 32'd0);
        @(posedge clk);
        #1;
        chk("ldi T+2 done",  {31'b0, done}, 32'd1);
        chk("ldi T+2 ready", {31'b0, instr_ready}, 32'd0);
        chk_rf("ldi T+2 rf1", 2'd1, 8'h00);
        @(posedge clk);
        #1;
        chk("ldi T+3 done",  {31'b0, done}, 32'd0);
        chk("ldi T+3 ready", {31'b0, instr_ready}, 32'd1);
        chk("ldi T+3 zero",  {31'b0, zero_flag}, 32'd0);
        chk("ldi T+3 aluop", {29'b0, alu_bus.alu_op}, 32'd0);
        chk_rf("ldi T+3 rf1", 2'd1, 8'h05);

        for (int i = 0; i < 14; i++) begin
            run_vec(tv[i]);
        end

        // Back-to-back with instr_valid held high
        nacc  = 0;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) ndone++;
            if (instr_ready) begin
                if (nacc < 3) begin
                    case (nacc)
                        0: instr = 9'b111_00_0001;
                        default: instr = 9'b000_00_00_00;
                    endcase
                    instr_valid = 1'b1;
                    acc_c[nacc] = c;
                    nacc++;
                end else begin
                    instr_valid = 1'b0;
                end
            end
        end
        instr_valid = 1'b0;
        chk("b2b accepts", nacc, 3);
        chk("b2b gap1", acc_c[1] - acc_c[0], 3);
        chk("b2b gap2", acc_c[2] - acc_c[1], 3);
        chk("b2b dones", ndone, 3);
        chk_rf("b2b rf0", 2'd0, 8'h03);

        // Reset during EXEC of LDI r3,9 after clearing r3
        run_vec('{"LDI r3,0", 9'b111_11_0000, 2'd3, 3'd7, 8'h00, 8'h00, 8'h00, 1'b1});
        @(negedge clk);
        instr       = 9'b111_11_1001;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        chk("mid exec op", {29'b0, alu_bus.alu_op}, 32'd7);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid rst ready", {31'b0, instr_ready}, 32'd1);
        chk("mid rst done",  {31'b0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("mid rst no done", ndone, 0);
        chk("mid rst zero", {31'b0, zero_flag}, 32'd0);
        chk_rf("mid rst rf3", 2'd3, 8'h00);
        chk_rf("mid rst rf1", 2'd1, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
